// File: rtl/mem_controller_pkg.sv
// Shared definitions for the byte-serial memory controller and its LoadStoreBuffer requester.
// Holds the FSM encoding, access direction codes, width codes and the IO region tag.
package mem_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LSB_READ,
    ST_IC_READ,
    ST_LSB_WRITE,
    ST_COOLDOWN
  } mc_state_t;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [2:0] WIDTH_BYTE = 3'd1;
  localparam logic [2:0] WIDTH_HALF = 3'd2;
  localparam logic [2:0] WIDTH_WORD = 3'd4;

  localparam logic [1:0] IO_MASK_HI = 2'b11;

  // Unknown width codes fall back to a full word.
  function automatic logic [2:0] width_to_len(input logic [2:0] width);
    case (width)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_controller.sv
// Byte-serial controller between the core (LSB loads/stores, IC fetches) and the 8-bit RAM/IO port.
// One RAM byte per cycle; a one-cycle cooldown after every transaction absorbs the requester's late en drop.
module mem_controller #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_MASK_HI = mem_controller_pkg::IO_MASK_HI
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  RoBMC_pre_judge,
  input  logic                  LSBMC_en,
  input  logic                  LSBMC_wr,
  input  logic [2:0]            LSBMC_data_width,
  input  logic [31:0]           LSBMC_data,
  input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
  output logic                  MCLSB_en,
  output logic [7:0]            MCLSB_data,
  output logic [1:0]            MCLSB_data_number,
  input  logic                  ICMC_en,
  input  logic [ADDR_WIDTH-1:0] ICMC_addr,
  output logic                  MCIC_en,
  output logic [31:0]           MCIC_inst,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);
  import mem_controller_pkg::*;

  mc_state_t             state_reg;
  logic [2:0]            cnt_reg;
  logic [2:0]            len_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           data_reg;
  logic                  mclsb_en_reg;
  logic [7:0]            mclsb_data_reg;
  logic [1:0]            mclsb_num_reg;
  logic                  mcic_en_reg;
  logic [31:0]           mcic_inst_reg;
  logic [7:0]            mem_dout_reg;
  logic [ADDR_WIDTH-1:0] mem_a_reg;
  logic                  mem_wr_reg;

  logic [2:0]            cnt_next;
  logic [2:0]            last_idx;
  logic [7:0]            wr_byte;
  logic                  accept_stall;
  logic                  write_stall;

  assign cnt_next = cnt_reg + 3'd1;
  assign last_idx = len_reg - 3'd1;
  assign wr_byte  = data_reg[{cnt_reg[1:0], 3'b000} +: 8];

  // IO writes wait while the IO buffer is full; the first byte can already be held off at accept.
  assign accept_stall = io_buffer_full && (LSBMC_addr[17:16] == IO_MASK_HI);
  assign write_stall  = io_buffer_full && (addr_reg[17:16] == IO_MASK_HI);

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 3'd0;
      len_reg        <= 3'd0;
      addr_reg       <= '0;
      data_reg       <= 32'd0;
      mclsb_en_reg   <= 1'b0;
      mclsb_data_reg <= 8'd0;
      mclsb_num_reg  <= 2'd0;
      mcic_en_reg    <= 1'b0;
      mcic_inst_reg  <= 32'd0;
      mem_dout_reg   <= 8'd0;
      mem_a_reg      <= '0;
      mem_wr_reg     <= 1'b0;
    end else if (Sys_rdy) begin
      mclsb_en_reg <= 1'b0;
      mcic_en_reg  <= 1'b0;
      mem_wr_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (RoBMC_pre_judge) begin
            if (LSBMC_en) begin
              addr_reg  <= LSBMC_addr;
              data_reg  <= LSBMC_data;
              len_reg   <= width_to_len(LSBMC_data_width);
              mem_a_reg <= LSBMC_addr;
              if (LSBMC_wr == WRITE) begin
                state_reg <= ST_LSB_WRITE;
                if (accept_stall) begin
                  cnt_reg <= 3'd0;
                end else begin
                  mem_dout_reg <= LSBMC_data[7:0];
                  mem_wr_reg   <= 1'b1;
                  cnt_reg      <= 3'd1;
                end
              end else begin
                cnt_reg   <= 3'd0;
                state_reg <= ST_LSB_READ;
              end
            end else if (ICMC_en) begin
              addr_reg  <= ICMC_addr;
              len_reg   <= 3'd4;
              mem_a_reg <= ICMC_addr;
              cnt_reg   <= 3'd0;
              state_reg <= ST_IC_READ;
            end
          end
        end

        ST_LSB_READ: begin
          if (!RoBMC_pre_judge) begin
            state_reg <= ST_COOLDOWN;
          end else begin
            mclsb_en_reg   <= 1'b1;
            mclsb_data_reg <= mem_din;
            mclsb_num_reg  <= cnt_reg[1:0];
            mem_a_reg      <= addr_reg + ADDR_WIDTH'(cnt_next);
            cnt_reg        <= cnt_next;
            if (cnt_reg == last_idx) state_reg <= ST_COOLDOWN;
          end
        end

        ST_IC_READ: begin
          if (!RoBMC_pre_judge) begin
            state_reg <= ST_COOLDOWN;
          end else begin
            mcic_inst_reg[{cnt_reg[1:0], 3'b000} +: 8] <= mem_din;
            mem_a_reg <= addr_reg + ADDR_WIDTH'(cnt_next);
            cnt_reg   <= cnt_next;
            if (cnt_reg == 3'd3) begin
              mcic_en_reg <= 1'b1;
              state_reg   <= ST_COOLDOWN;
            end
          end
        end

        // Stores are already committed, so a flush does not interrupt them.
        ST_LSB_WRITE: begin
          if (cnt_reg < len_reg) begin
            if (!write_stall) begin
              mem_a_reg    <= addr_reg + ADDR_WIDTH'(cnt_reg);
              mem_dout_reg <= wr_byte;
              mem_wr_reg   <= 1'b1;
              cnt_reg      <= cnt_next;
            end
          end else begin
            mclsb_en_reg  <= 1'b1;
            mclsb_num_reg <= last_idx[1:0];
            state_reg     <= ST_COOLDOWN;
          end
        end

        ST_COOLDOWN: state_reg <= ST_IDLE;

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign MCLSB_en          = mclsb_en_reg;
  assign MCLSB_data        = mclsb_data_reg;
  assign MCLSB_data_number = mclsb_num_reg;
  assign MCIC_en           = mcic_en_reg;
  assign MCIC_inst         = mcic_inst_reg;
  assign mem_dout          = mem_dout_reg;
  assign mem_a             = mem_a_reg;
  assign mem_wr            = mem_wr_reg & Sys_rdy;

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: directed vector table, hand-written corner sequences,
// and random LSB/IC traffic checked against a byte-array memory model.
module tb_mem_controller;
  import mem_controller_pkg::*;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst, Sys_rdy, RoBMC_pre_judge;
  logic        LSBMC_en, LSBMC_wr;
  logic [2:0]  LSBMC_data_width;
  logic [31:0] LSBMC_data, LSBMC_addr;
  logic        MCLSB_en;
  logic [7:0]  MCLSB_data;
  logic [1:0]  MCLSB_data_number;
  logic        ICMC_en;
  logic [31:0] ICMC_addr;
  logic        MCIC_en;
  logic [31:0] MCIC_inst;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  mem_controller dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy), .RoBMC_pre_judge(RoBMC_pre_judge),
    .LSBMC_en(LSBMC_en), .LSBMC_wr(LSBMC_wr), .LSBMC_data_width(LSBMC_data_width),
    .LSBMC_data(LSBMC_data), .LSBMC_addr(LSBMC_addr),
    .MCLSB_en(MCLSB_en), .MCLSB_data(MCLSB_data), .MCLSB_data_number(MCLSB_data_number),
    .ICMC_en(ICMC_en), .ICMC_addr(ICMC_addr), .MCIC_en(MCIC_en), .MCIC_inst(MCIC_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 Sys_clk = ~Sys_clk;

  // RAM seen by the DUT: read data for the address presented in the current cycle.
  logic [7:0] ram     [0:4095];
  logic [7:0] ref_mem [0:4095];
  assign mem_din = ram[mem_a[11:0]];
  always @(negedge Sys_clk) if (mem_wr === 1'b1) ram[mem_a[11:0]] <= mem_dout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [1:0]  exp_num;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Sys_clk);
    #1;
    cyc++;
  endtask

  function automatic int ref_len(input logic [2:0] w);
    return (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_mem[12'(a + 32'(i))];
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) ref_mem[12'(a + 32'(i))] = d[8*i +: 8];
  endtask

  // One LSB transaction with unstalled timing checks; en is held one cycle past completion.
  task automatic lsb_txn(input logic wr, input logic [2:0] width, input logic [31:0] addr,
                         input logic [31:0] wdata, input int flush_at,
                         output logic [31:0] rd_word, output logic [1:0] last_num);
    int n, c0, nbytes, nwr;
    bit done;
    n = ref_len(width);
    rd_word = 32'd0; last_num = 2'd0; nbytes = 0; nwr = 0; done = 0; c0 = cyc;
    LSBMC_en = 1'b1; LSBMC_wr = wr; LSBMC_data_width = width; LSBMC_addr = addr; LSBMC_data = wdata;
    for (int k = 0; k < 16 && !done; k++) begin
      RoBMC_pre_judge = (k == flush_at) ? 1'b0 : 1'b1;
      step();
      if (k == 0) begin
        c0 = cyc;
        chk("accept_addr", mem_a, addr);
      end
      if (mem_wr && nwr < 4) begin
        chk("wr_cycle", cyc - c0, nwr);
        chk("wr_addr", mem_a, addr + 32'(nwr));
        chk("wr_data", {24'd0, mem_dout}, {24'd0, wdata[8*nwr +: 8]});
        nwr++;
      end
      if (MCLSB_en) begin
        if (wr) begin
          chk("wr_done_cycle", cyc - c0, n);
          last_num = MCLSB_data_number;
          done = 1;
        end else begin
          chk("rd_byte_cycle", cyc - c0, nbytes + 1);
          chk("rd_num", {30'd0, MCLSB_data_number}, nbytes);
          if (nbytes < 4) rd_word[8*nbytes +: 8] = MCLSB_data;
          last_num = MCLSB_data_number;
          nbytes++;
          if (nbytes == n) done = 1;
        end
      end
    end
    RoBMC_pre_judge = 1'b1;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL lsb_timeout: got no completion, expected one within 16 cycles");
    end else begin
      chk("wr_count", nwr, wr ? n : 0);
    end
    step();
    chk("cooldown_quiet", {30'd0, MCLSB_en, mem_wr}, 32'd0);
    LSBMC_en = 1'b0;
    $display("lsb %s width=%0d addr=%h wdata=%h -> word=%h num=%0d", wr ? "wr" : "rd",
             width, addr, wdata, rd_word, last_num);
  endtask

  task automatic ic_txn(input logic [31:0] addr, output logic [31:0] inst);
    int c0;
    bit done;
    done = 0; inst = 32'd0; c0 = cyc;
    ICMC_en = 1'b1; ICMC_addr = addr;
    for (int k = 0; k < 16 && !done; k++) begin
      step();
      if (k == 0) c0 = cyc;
      chk("ic_no_lsb_en", {31'd0, MCLSB_en}, 32'd0);
      if (MCIC_en) begin
        chk("ic_cycle", cyc - c0, 4);
        inst = MCIC_inst;
        done = 1;
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL ic_timeout: got no MCIC_en, expected one within 16 cycles");
    end
    step();
    chk("ic_pulse_one_cycle", {31'd0, MCIC_en}, 32'd0);
    ICMC_en = 1'b0;
    $display("ic addr=%h -> inst=%h", addr, inst);
  endtask

  logic [31:0] w, lsb_word, a;
  logic [1:0]  num;
  logic [2:0]  wd;
  int          c0, nb, sel;
  bit          ic_seen;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h120] = 8'h78; ram[12'h121] = 8'h56; ram[12'h122] = 8'h34; ram[12'h123] = 8'h12;
    for (int i = 0; i < 4; i++) begin
      ref_mem[12'h100 + 12'(i)] = ram[12'h100 + 12'(i)];
      ref_mem[12'h120 + 12'(i)] = ram[12'h120 + 12'(i)];
    end

    Sys_rst = 1'b0; Sys_rdy = 1'b1; RoBMC_pre_judge = 1'b1;
    LSBMC_en = 1'b0; LSBMC_wr = READ; LSBMC_data_width = WIDTH_WORD; LSBMC_data = 32'd0;
    LSBMC_addr = 32'd0; ICMC_en = 1'b0; ICMC_addr = 32'd0; io_buffer_full = 1'b0;
    #1 Sys_rst = 1'b1;
    #2;
    chk("rst_mclsb_en", {31'd0, MCLSB_en}, 0);
    chk("rst_mclsb_data", {24'd0, MCLSB_data}, 0);
    chk("rst_mclsb_num", {30'd0, MCLSB_data_number}, 0);
    chk("rst_mcic_en", {31'd0, MCIC_en}, 0);
    chk("rst_mcic_inst", MCIC_inst, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    step(); step();
    Sys_rst = 1'b0;
    step();

    vecs[0]  = '{READ,  3'd4, 32'h100, 32'h0,        32'h44332211, 2'd3};
    vecs[1]  = '{WRITE, 3'd2, 32'h200, 32'h0000BEEF, 32'h0,        2'd1};
    vecs[2]  = '{READ,  3'd2, 32'h200, 32'h0,        32'h0000BEEF, 2'd1};
    vecs[3]  = '{WRITE, 3'd4, 32'h204, 32'hDEADBEEF, 32'h0,        2'd3};
    vecs[4]  = '{READ,  3'd1, 32'h206, 32'h0,        32'h000000AD, 2'd0};
    vecs[5]  = '{READ,  3'd7, 32'h204, 32'h0,        32'hDEADBEEF, 2'd3};
    vecs[6]  = '{WRITE, 3'd1, 32'h0FF, 32'h0000005A, 32'h0,        2'd0};
    vecs[7]  = '{READ,  3'd2, 32'h0FF, 32'h0,        32'h0000115A, 2'd1};
    vecs[8]  = '{WRITE, 3'd0, 32'h300, 32'h01020304, 32'h0,        2'd3};
    vecs[9]  = '{READ,  3'd4, 32'h300, 32'h0,        32'h01020304, 2'd3};
    vecs[10] = '{READ,  3'd4, 32'h120, 32'h0,        32'h12345678, 2'd3};
    for (int v = 0; v < 11; v++) begin
      lsb_txn(vecs[v].wr, vecs[v].width, vecs[v].addr, vecs[v].wdata, -1, w, num);
      chk($sformatf("vec%0d_num", v), {30'd0, num}, {30'd0, vecs[v].exp_num});
      if (vecs[v].wr) ref_store(vecs[v].addr, vecs[v].wdata, ref_len(vecs[v].width));
      else chk($sformatf("vec%0d_rdata", v), w, vecs[v].exp_rd);
    end

    // IO write held off by a full buffer for three edges.
    io_buffer_full = 1'b1;
    LSBMC_en = 1'b1; LSBMC_wr = WRITE; LSBMC_data_width = 3'd1; LSBMC_addr = 32'h30000; LSBMC_data = 32'h41;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("io_stall_no_wr", {31'd0, mem_wr}, 0);
      chk("io_stall_no_done", {31'd0, MCLSB_en}, 0);
    end
    io_buffer_full = 1'b0;
    step();
    chk("io_wr_after_release", {31'd0, mem_wr}, 1);
    chk("io_wr_addr", mem_a, 32'h30000);
    chk("io_wr_data", {24'd0, mem_dout}, 32'h41);
    step();
    chk("io_done_pulse", {29'd0, MCLSB_en, MCLSB_data_number}, 32'h4);
    chk("io_single_write", {31'd0, mem_wr}, 0);
    step();
    LSBMC_en = 1'b0;
    chk("io_cooldown_quiet", {31'd0, MCLSB_en}, 0);
    $display("lsb wr width=1 addr=00030000 wdata=00000041 io stalled 3 cycles");

    // Full buffer does not stall writes outside the IO region.
    io_buffer_full = 1'b1;
    lsb_txn(WRITE, 3'd2, 32'h20180, 32'h0000C0DE, -1, w, num);
    ref_store(32'h20180, 32'h0000C0DE, 2);
    io_buffer_full = 1'b0;

    // LSB and IC together: LSB first, IC after the LSB cooldown.
    LSBMC_en = 1'b1; LSBMC_wr = READ; LSBMC_data_width = 3'd4; LSBMC_addr = 32'h100;
    ICMC_en = 1'b1; ICMC_addr = 32'h120;
    lsb_word = 32'd0; nb = 0; ic_seen = 0; c0 = cyc;
    for (int k = 0; k < 20 && !ic_seen; k++) begin
      step();
      if (k == 0) begin
        c0 = cyc;
        chk("arb_lsb_first", mem_a, 32'h100);
      end
      if (MCLSB_en) begin
        lsb_word[8*MCLSB_data_number +: 8] = MCLSB_data;
        nb++;
      end
      if (MCIC_en) begin
        chk("arb_ic_cycle", cyc - c0, 10);
        chk("arb_ic_inst", MCIC_inst, 32'h12345678);
        ic_seen = 1;
      end
      if (cyc - c0 == 5) LSBMC_en = 1'b0;
    end
    chk("arb_ic_seen", {31'd0, ic_seen}, 1);
    chk("arb_lsb_word", lsb_word, 32'h44332211);
    chk("arb_lsb_bytes", nb, 4);
    step();
    ICMC_en = 1'b0;
    $display("arb lsb rd 00000100 -> %h, ic 00000120 served after", lsb_word);

    // Flush during the second byte of a word load.
    LSBMC_en = 1'b1; LSBMC_wr = READ; LSBMC_data_width = 3'd4; LSBMC_addr = 32'h100;
    step();
    step();
    chk("flush_byte0_en", {31'd0, MCLSB_en}, 1);
    chk("flush_byte0_data", {24'd0, MCLSB_data}, 32'h11);
    RoBMC_pre_judge = 1'b0; LSBMC_en = 1'b0;
    step();
    chk("flush_no_byte1", {31'd0, MCLSB_en}, 0);
    RoBMC_pre_judge = 1'b1;
    LSBMC_en = 1'b1; LSBMC_wr = READ; LSBMC_data_width = 3'd1; LSBMC_addr = 32'h120;
    step();
    chk("flush_cooldown_no_accept", {31'd0, mem_a == 32'h120}, 0);
    chk("flush_cooldown_quiet", {31'd0, MCLSB_en}, 0);
    lsb_txn(READ, 3'd1, 32'h120, 32'h0, -1, w, num);
    chk("flush_next_rdata", w, 32'h78);
    $display("flush rd aborted after byte 0, next lb -> %h", w);

    // Flush during a store does not stop it.
    lsb_txn(WRITE, 3'd4, 32'h140, 32'h11223344, 2, w, num);
    ref_store(32'h140, 32'h11223344, 4);
    chk("flush_sw_num", {30'd0, num}, 3);
    lsb_txn(READ, 3'd4, 32'h140, 32'h0, -1, w, num);
    chk("flush_sw_readback", w, 32'h11223344);

    // Flush in idle and Sys_rdy low both keep a pending store from starting.
    LSBMC_en = 1'b1; LSBMC_wr = WRITE; LSBMC_data_width = 3'd1; LSBMC_addr = 32'h160; LSBMC_data = 32'h99;
    RoBMC_pre_judge = 1'b0;
    step();
    chk("idle_flush_no_wr", {31'd0, mem_wr}, 0);
    chk("idle_flush_no_accept", {31'd0, mem_a == 32'h160}, 0);
    RoBMC_pre_judge = 1'b1; Sys_rdy = 1'b0;
    step(); step();
    chk("rdy_low_no_wr", {31'd0, mem_wr}, 0);
    chk("rdy_low_no_accept", {31'd0, mem_a == 32'h160}, 0);
    Sys_rdy = 1'b1;
    lsb_txn(WRITE, 3'd1, 32'h160, 32'h99, -1, w, num);
    ref_store(32'h160, 32'h99, 1);

    // En held past completion must not start a second store.
    lsb_txn(WRITE, 3'd1, 32'h180, 32'h77, -1, w, num);
    ref_store(32'h180, 32'h77, 1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("held_en_no_second", {30'd0, MCLSB_en, mem_wr}, 0);
    end

    // Reset in the middle of a load: outputs clear at once, no partial completion.
    LSBMC_en = 1'b1; LSBMC_wr = READ; LSBMC_data_width = 3'd4; LSBMC_addr = 32'h100;
    step(); step();
    #2 Sys_rst = 1'b1;
    #1;
    chk("midrst_mclsb_en", {31'd0, MCLSB_en}, 0);
    chk("midrst_mem_a", mem_a, 0);
    chk("midrst_mclsb_data", {24'd0, MCLSB_data}, 0);
    LSBMC_en = 1'b0;
    step();
    Sys_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_no_partial", {31'd0, MCLSB_en}, 0);
    end

    // Random traffic against the byte-array model.
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 3));
      a = 32'h400 + 32'($urandom_range(0, 32'hBF0));
      if (sel == 3) begin
        ic_txn(a, w);
        chk($sformatf("rnd%0d_ic", t), w, ref_word(a, 4));
      end else begin
        nb = int'($urandom_range(0, 3));
        wd = (nb == 0) ? 3'd1 : (nb == 1) ? 3'd2 : (nb == 2) ? 3'd4 : 3'($urandom_range(0, 7));
        if (sel == 0) begin
          lsb_word = $urandom;
          lsb_txn(WRITE, wd, a, lsb_word, -1, w, num);
          ref_store(a, lsb_word, ref_len(wd));
        end else begin
          lsb_txn(READ, wd, a, 32'h0, -1, w, num);
          chk($sformatf("rnd%0d_rdata", t), w, ref_word(a, ref_len(wd)));
        end
        chk($sformatf("rnd%0d_num", t), {30'd0, num}, 32'(ref_len(wd) - 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
